// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//
// Front end for a wrap-around up/down counter. Takes a raw two-channel
// quadrature encoder, synchronises and debounces each channel, decodes the
// Gray-code steps and accumulates them into whole detents. Each completed
// detent produces a single-cycle plus or minus pulse. A step where both
// channels change in the same decode cycle cannot be resolved; it raises a
// one-cycle err pulse and a sticky err_flag.
//
// Parameters
//   DEBOUNCE        consecutive differing cycles before a filtered channel
//                   follows its synchronised input (>= 1)
//   STEPS_PER_PULSE legal quadrature steps per output pulse (1, 2 or 4)
//   INVERT_DIR      1 swaps the roles of plus and minus (err unaffected)
//
// Ports
//   clk      in   single clock, everything on posedge
//   rst_n    in   asynchronous active-low reset
//   enc_a    in   encoder channel A, asynchronous to clk
//   enc_b    in   encoder channel B, asynchronous to clk
//   err_clr  in   synchronous clear of err_flag (a new error wins)
//   plus     out  1-cycle pulse, forward detent completed
//   minus    out  1-cycle pulse, reverse detent completed
//   err      out  1-cycle pulse, illegal transition seen
//   err_flag out  sticky illegal-transition indicator
//
// Timing: a pin change first sampled at edge k updates the filtered value
// at edge k+1+DEBOUNCE; any resulting pulse is high from edge k+2+DEBOUNCE.
// -----------------------------------------------------------------------------
module quad_step_decoder #(
    parameter int DEBOUNCE        = 16,
    parameter int STEPS_PER_PULSE = 4,
    parameter bit INVERT_DIR      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enc_a,
    input  logic enc_b,
    input  logic err_clr,
    output logic plus,
    output logic minus,
    output logic err,
    output logic err_flag
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int CNT_W       = $clog2(DEBOUNCE + 1);
    // The filter output cannot be trusted until the two synchroniser stages
    // have filled and a full debounce window has elapsed behind them.
    localparam int WARM_CYCLES = DEBOUNCE + 2;
    localparam int WARM_W      = $clog2(WARM_CYCLES + 1);
    localparam int ACC_W       = $clog2(STEPS_PER_PULSE + 1) + 1;

    // The counter fires on the DEBOUNCE-th consecutive mismatch, so it only
    // needs to count to DEBOUNCE-1 before the update edge.
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [WARM_W-1:0]       WARM_MAX = WARM_W'(WARM_CYCLES);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'(STEPS_PER_PULSE);
    localparam logic signed [ACC_W-1:0] ACC_MIN  = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);

    // Channel index: bit 1 = A, bit 0 = B, so {A,B} reads naturally as a pair.
    localparam int CH_A = 1;
    localparam int CH_B = 0;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [1:0]              r_sync_a;        // [0] first stage, [1] second
    logic [1:0]              r_sync_b;
    logic [1:0]              w_s;             // synchronised {A,B}
    logic [1:0]              r_f;             // debounced {A,B}
    logic [CNT_W-1:0]        r_db_cnt [2];
    logic [WARM_W-1:0]       r_warm_cnt;
    logic                    w_warm_done;
    logic [1:0]              r_valid;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [1:0]              r_prev;
    logic signed [ACC_W-1:0] r_acc;
    logic [1:0]              w_prev_next;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_acc_inc;
    logic signed [ACC_W-1:0] w_acc_dec;

    logic [1:0]              w_changed;
    logic                    w_phase;
    logic                    w_illegal;
    logic                    w_step_fwd;
    logic                    w_step_rev;

    logic                    w_fwd_pulse;
    logic                    w_rev_pulse;
    logic                    w_err_next;

    logic                    r_plus;
    logic                    r_minus;
    logic                    r_err;
    logic                    r_err_flag;

    // -------------------------------------------------------------------------
    // Two-flop synchronisers
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its source, exactly as the hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[0], enc_a};
            r_sync_b <= {r_sync_b[0], enc_b};
        end
    end

    assign w_s[CH_A] = r_sync_a[1];
    assign w_s[CH_B] = r_sync_b[1];

    // -------------------------------------------------------------------------
    // Debounce filter: the filtered value follows the synchronised value only
    // after DEBOUNCE consecutive cycles of disagreement. Any shorter run is
    // discarded because a single agreeing cycle clears the counter.
    // -------------------------------------------------------------------------
    // NOTE: these counters are ordinary flops, so they are reset like any
    // other register; only RAM-style storage is left out of a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_s[i] == r_f[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == CNT_LAST) begin
                    r_f[i]      <= w_s[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel valid: set once the warm-up window has passed and the
    // channel is not in the middle of a pending change, so the position
    // captured in INIT is the real resting position of the encoder.
    // -------------------------------------------------------------------------
    assign w_warm_done = (r_warm_cnt == WARM_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm_cnt <= '0;
            r_valid    <= '0;
        end else begin
            if (!w_warm_done) begin
                r_warm_cnt <= r_warm_cnt + WARM_W'(1);
            end
            for (int i = 0; i < 2; i++) begin
                if (w_warm_done && (r_db_cnt[i] == '0)) begin
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Step classification
    // Position order (A leads B): 00 -> 10 -> 11 -> 01 -> 00.
    // When A and B are equal (00, 11) a forward step moves A; when they
    // differ (10, 01) a forward step moves B. The opposite channel moving
    // means a reverse step; both moving is unresolvable.
    // -------------------------------------------------------------------------
    assign w_changed  = r_f ^ r_prev;
    assign w_phase    = r_prev[CH_A] ^ r_prev[CH_B];
    assign w_illegal  = &w_changed;
    assign w_step_fwd = ((w_changed == 2'b10) && !w_phase) ||
                        ((w_changed == 2'b01) &&  w_phase);
    assign w_step_rev = ((w_changed == 2'b10) &&  w_phase) ||
                        ((w_changed == 2'b01) && !w_phase);

    assign w_acc_inc  = r_acc + ACC_ONE;
    assign w_acc_dec  = r_acc - ACC_ONE;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_INIT:  if (&r_valid) w_state_next = ST_TRACK;
            ST_TRACK: w_state_next = ST_TRACK;
            default:  w_state_next = ST_INIT;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath logic
    // INIT captures the resting position without producing a pulse. TRACK
    // follows the filtered pair every cycle and folds steps into the signed
    // accumulator; a reversal simply walks the accumulator back.
    // -------------------------------------------------------------------------
    always_comb begin
        w_prev_next = r_prev;
        w_acc_next  = r_acc;
        w_fwd_pulse = 1'b0;
        w_rev_pulse = 1'b0;
        w_err_next  = 1'b0;

        unique case (r_state)
            ST_INIT: begin
                if (&r_valid) begin
                    w_prev_next = r_f;
                    w_acc_next  = '0;
                end
            end

            ST_TRACK: begin
                w_prev_next = r_f;
                if (w_illegal) begin
                    w_acc_next = '0;
                    w_err_next = 1'b1;
                end else if (w_step_fwd) begin
                    if (w_acc_inc == ACC_MAX) begin
                        w_acc_next  = '0;
                        w_fwd_pulse = 1'b1;
                    end else begin
                        w_acc_next  = w_acc_inc;
                    end
                end else if (w_step_rev) begin
                    if (w_acc_dec == ACC_MIN) begin
                        w_acc_next  = '0;
                        w_rev_pulse = 1'b1;
                    end else begin
                        w_acc_next  = w_acc_dec;
                    end
                end
            end

            default: begin
                w_acc_next = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_acc      <= '0;
            r_plus     <= 1'b0;
            r_minus    <= 1'b0;
            r_err      <= 1'b0;
            r_err_flag <= 1'b0;
        end else begin
            r_prev     <= w_prev_next;
            r_acc      <= w_acc_next;
            // Direction swap only touches plus/minus; both are never high
            // together because at most one of the pulse terms is set.
            r_plus     <= INVERT_DIR ? w_rev_pulse : w_fwd_pulse;
            r_minus    <= INVERT_DIR ? w_fwd_pulse : w_rev_pulse;
            r_err      <= w_err_next;
            // A new error in the same cycle as err_clr keeps the flag set.
            r_err_flag <= w_err_next | (r_err_flag & ~err_clr);
        end
    end

    assign plus     = r_plus;
    assign minus    = r_minus;
    assign err      = r_err;
    assign err_flag = r_err_flag;

endmodule
